// File: rtl/multimode_shift_reg_if.sv
// rtl/multimode_shift_reg_if.sv - command/status bundle for multimode_shift_reg
interface multimode_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             clr;
    logic [2:0]       mode;
    logic [WIDTH-1:0] in;
    logic             sin;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] shcnt;
    logic             zero;

    modport master (
        output clr, mode, in, sin, amt,
        input  out, busy, done, shcnt, zero
    );

    modport slave (
        input  clr, mode, in, sin, amt,
        output out, busy, done, shcnt, zero
    );
endinterface

// File: rtl/multimode_shift_reg.sv
// rtl/multimode_shift_reg.sv - load/shift/rotate register with multi-cycle shift-right-by-N
// Optional normalise (mode 111, strip trailing zeros) enabled by MULTIMODE_SHIFT_REG_NORMALIZE_EN.
module multimode_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    multimode_shift_reg_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef MULTIMODE_SHIFT_REG_NORMALIZE_EN
        , NORM
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shcnt_q;
    logic             busy_q;
    logic             done_q;

    assign bus.out   = data;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.shcnt = shcnt_q;
    assign bus.zero  = (data == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            data    <= '0;
            cnt     <= '0;
            shcnt_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clr) begin
                state   <= IDLE;
                data    <= '0;
                cnt     <= '0;
                shcnt_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    SHIFT: begin
                        data    <= {bus.sin, data[WIDTH-1:1]};
                        shcnt_q <= shcnt_q + CNT_W'(1);
                        cnt     <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
`ifdef MULTIMODE_SHIFT_REG_NORMALIZE_EN
                    NORM: begin
                        data    <= data >> 1;
                        shcnt_q <= shcnt_q + CNT_W'(1);
                        // Stop once the bit about to land in the LSB is a one.
                        if (data[1]) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
`endif
                    IDLE: begin
                        case (bus.mode)
                            3'b001: data <= bus.in;
                            3'b010: data <= {data[WIDTH-2:0], bus.sin};
                            3'b011: data <= {bus.sin, data[WIDTH-1:1]};
                            3'b100: data <= {data[WIDTH-2:0], data[WIDTH-1]};
                            3'b101: data <= {data[0], data[WIDTH-1:1]};
                            3'b110: begin
                                shcnt_q <= '0;
                                if (bus.amt == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    cnt    <= bus.amt;
                                    state  <= SHIFT;
                                    busy_q <= 1'b1;
                                end
                            end
`ifdef MULTIMODE_SHIFT_REG_NORMALIZE_EN
                            3'b111: begin
                                shcnt_q <= '0;
                                if (data == '0 || data[0]) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state  <= NORM;
                                    busy_q <= 1'b1;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multimode_shift_reg.sv
// tb/tb_multimode_shift_reg.sv - randomized self-checking bench for multimode_shift_reg
module tb_multimode_shift_reg;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam logic [WIDTH-1:0] MASK = '1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [WIDTH-1:0] m_out;
    int               m_shcnt;

    multimode_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    multimode_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.clr = 1'b0; bus.mode = 3'b000; bus.in = '0; bus.sin = 1'b0; bus.amt = '0;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        bus.mode = 3'b001; bus.in = v;
        tick;
        bus.mode = 3'b000;
    endtask

    task automatic test_reset;
        idle_inputs;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out !== '0) begin n_fail++; $display("FAIL reset_out actual=%h required=00", bus.out); end
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b done=%b required=0/0", bus.busy, bus.done); end
        n_checks++; if (bus.shcnt !== '0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset_shcnt_zero shcnt=%0d zero=%b required=0/1", bus.shcnt, bus.zero); end
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_load_flag;
        load(8'hA5);
        n_checks++; if (bus.out !== 8'hA5 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL load out=%h zero=%b required=a5/0", bus.out, bus.zero); end
        bus.clr = 1'b1; tick; bus.clr = 1'b0;
        n_checks++; if (bus.out !== '0 || bus.zero !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr out=%h zero=%b busy=%b required=00/1/0", bus.out, bus.zero, bus.busy); end
    endtask

    task automatic test_single_cycle;
        logic [WIDTH-1:0] start [4] = '{8'h81, 8'h81, 8'h81, 8'h02};
        logic [WIDTH-1:0] want  [4] = '{8'h03, 8'hC0, 8'h02, 8'h81};
        logic [2:0]       md    [4] = '{3'b100, 3'b101, 3'b010, 3'b011};
        logic             fill  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            load(start[i]);
            bus.mode = md[i]; bus.sin = fill[i];
            tick;
            bus.mode = 3'b000;
            n_checks++; if (bus.out !== want[i] || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL single_mode%0d out=%h busy=%b done=%b required=%h/0/0", md[i], bus.out, bus.busy, bus.done, want[i]); end
        end
    endtask

    task automatic test_multi_shift;
        int cycles;
        load(8'hF0);
        bus.mode = 3'b110; bus.amt = 4'd3; bus.sin = 1'b0;
        tick;
        n_checks++; if (bus.busy !== 1'b1 || bus.out !== 8'hF0 || bus.shcnt !== '0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mshift_start busy=%b out=%h shcnt=%0d done=%b required=1/f0/0/0", bus.busy, bus.out, bus.shcnt, bus.done); end
        bus.mode = 3'b001; bus.in = 8'hFF;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 20) begin
            n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mshift_early_done cycle=%0d done=%b required=0", cycles, bus.done); end
            tick; cycles++;
        end
        n_checks++; if (cycles !== 3) begin n_fail++; $display("FAIL mshift_busy_cycles actual=%0d required=3", cycles); end
        n_checks++; if (bus.out !== 8'h1E || bus.done !== 1'b1 || bus.shcnt !== 4'd3) begin n_fail++; $display("FAIL mshift_result out=%h done=%b shcnt=%0d required=1e/1/3", bus.out, bus.done, bus.shcnt); end
        bus.mode = 3'b000;
        tick;
        n_checks++; if (bus.done !== 1'b0 || bus.out !== 8'h1E || bus.shcnt !== 4'd3) begin n_fail++; $display("FAIL mshift_after out=%h done=%b shcnt=%0d required=1e/0/3", bus.out, bus.done, bus.shcnt); end
    endtask

    task automatic test_amt_zero;
        load(8'h5A);
        bus.mode = 3'b110; bus.amt = '0;
        tick;
        bus.mode = 3'b000;
        n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out !== 8'h5A || bus.shcnt !== '0) begin n_fail++; $display("FAIL amt0 done=%b busy=%b out=%h shcnt=%0d required=1/0/5a/0", bus.done, bus.busy, bus.out, bus.shcnt); end
        tick;
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL amt0_after done=%b busy=%b required=0/0", bus.done, bus.busy); end
    endtask

    task automatic test_abort;
        load(8'hC3);
        bus.mode = 3'b110; bus.amt = 4'd5; bus.sin = 1'b1;
        tick; bus.mode = 3'b000;
        tick; tick;
        n_checks++; if (bus.out !== 8'hF0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_mid out=%h busy=%b required=f0/1", bus.out, bus.busy); end
        bus.clr = 1'b1; tick; bus.clr = 1'b0;
        n_checks++; if (bus.out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.shcnt !== '0) begin n_fail++; $display("FAIL abort_clr out=%h busy=%b done=%b shcnt=%0d required=00/0/0/0", bus.out, bus.busy, bus.done, bus.shcnt); end
        for (int i = 0; i < 5; i++) begin
            tick;
            n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_clr_tail cycle=%0d done=%b busy=%b required=0/0", i, bus.done, bus.busy); end
        end
        load(8'h3C);
        bus.mode = 3'b110; bus.amt = 4'd5; bus.sin = 1'b0;
        tick; bus.mode = 3'b000;
        tick;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.shcnt !== '0) begin n_fail++; $display("FAIL abort_rst out=%h busy=%b done=%b shcnt=%0d required=00/0/0/0", bus.out, bus.busy, bus.done, bus.shcnt); end
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out !== '0) begin n_fail++; $display("FAIL abort_rst_tail cycle=%0d done=%b busy=%b out=%h required=0/0/00", i, bus.done, bus.busy, bus.out); end
        end
    endtask

    task automatic test_mode7;
`ifdef MULTIMODE_SHIFT_REG_NORMALIZE_EN
        int cycles;
        load(8'h28);
        bus.mode = 3'b111; tick; bus.mode = 3'b000;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 20) begin tick; cycles++; end
        n_checks++; if (bus.out !== 8'h05 || bus.shcnt !== 4'd3 || bus.done !== 1'b1 || cycles !== 3) begin n_fail++; $display("FAIL norm_28 out=%h shcnt=%0d done=%b cycles=%0d required=05/3/1/3", bus.out, bus.shcnt, bus.done, cycles); end
        tick;
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL norm_done_width done=%b required=0", bus.done); end
        load(8'h00);
        bus.mode = 3'b111; tick; bus.mode = 3'b000;
        n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.shcnt !== '0 || bus.out !== '0) begin n_fail++; $display("FAIL norm_zero done=%b busy=%b shcnt=%0d out=%h required=1/0/0/00", bus.done, bus.busy, bus.shcnt, bus.out); end
`else
        load(8'h28);
        bus.mode = 3'b111; tick;
        n_checks++; if (bus.out !== 8'h28 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mode7_hold out=%h done=%b busy=%b required=28/0/0", bus.out, bus.done, bus.busy); end
        tick; bus.mode = 3'b000;
        n_checks++; if (bus.out !== 8'h28 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mode7_hold2 out=%h done=%b busy=%b required=28/0/0", bus.out, bus.done, bus.busy); end
`endif
    endtask

    // Runs one multi-cycle command already presented on bus.mode; garbage commands are fed while busy.
    task automatic run_multi(input logic [WIDTH-1:0] exp_out, input int exp_n, input int iter);
        int cycles;
        tick;
        if (exp_n == 0) begin
            n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out !== m_out || bus.shcnt !== '0) begin n_fail++; $display("FAIL rnd_multi0 iter=%0d done=%b busy=%b out=%h shcnt=%0d required=1/0/%h/0", iter, bus.done, bus.busy, bus.out, bus.shcnt, m_out); end
        end else begin
            cycles = 0;
            while (bus.busy === 1'b1 && cycles < 40) begin
                bus.mode = 3'($urandom_range(0, 7)); bus.in = WIDTH'($urandom); bus.amt = CNT_W'($urandom);
                tick; cycles++;
            end
            n_checks++; if (cycles !== exp_n || bus.done !== 1'b1 || bus.out !== exp_out || bus.shcnt !== CNT_W'(exp_n)) begin n_fail++; $display("FAIL rnd_multi iter=%0d cycles=%0d done=%b out=%h shcnt=%0d required=%0d/1/%h/%0d", iter, cycles, bus.done, bus.out, bus.shcnt, exp_n, exp_out, exp_n); end
        end
        m_out = exp_out;
        m_shcnt = exp_n;
        bus.mode = 3'b000;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] ones;
        logic [2:0]       md;
        int               a;
        int               tz;
        ones = '1;
        idle_inputs;
        m_out = WIDTH'($urandom);
        load(m_out);
        m_shcnt = int'(bus.shcnt);
        for (int it = 0; it < 200; it++) begin
            md = 3'($urandom_range(0, 7));
            bus.in = WIDTH'($urandom); bus.sin = 1'($urandom); bus.amt = CNT_W'($urandom_range(0, WIDTH + 3));
            bus.mode = md;
            if ($urandom_range(0, 24) == 0) begin
                bus.clr = 1'b1; tick; bus.clr = 1'b0;
                m_out = '0; m_shcnt = 0;
            end else if (md == 3'b110) begin
                a = int'(bus.amt);
                exp = (m_out >> a) | (bus.sin ? ~(ones >> a) : '0);
                run_multi(exp, a, it);
`ifdef MULTIMODE_SHIFT_REG_NORMALIZE_EN
            end else if (md == 3'b111) begin
                tz = 0;
                exp = m_out;
                if (exp != '0) while (exp[0] == 1'b0) begin exp = exp >> 1; tz++; end
                run_multi(exp, tz, it);
`endif
            end else begin
                case (md)
                    3'b001:  exp = bus.in;
                    3'b010:  exp = (m_out << 1) | WIDTH'(bus.sin);
                    3'b011:  exp = (m_out >> 1) | (WIDTH'(bus.sin) << (WIDTH - 1));
                    3'b100:  exp = (m_out << 1) | (m_out >> (WIDTH - 1));
                    3'b101:  exp = (m_out >> 1) | (m_out << (WIDTH - 1));
                    default: exp = m_out;
                endcase
                tick;
                m_out = exp & MASK;
            end
            bus.mode = 3'b000;
            n_checks++; if (bus.out !== m_out || bus.zero !== (m_out == '0) || bus.shcnt !== CNT_W'(m_shcnt)) begin n_fail++; $display("FAIL rnd_state iter=%0d mode=%0d out=%h zero=%b shcnt=%0d required=%h/%b/%0d", it, md, bus.out, bus.zero, bus.shcnt, m_out, (m_out == '0), m_shcnt); end
            if (md != 3'b110 && md != 3'b111) begin
                n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rnd_single_flags iter=%0d busy=%b done=%b required=0/0", it, bus.busy, bus.done); end
            end
        end
        tz = 0;
    endtask

    initial begin
        idle_inputs;
        test_reset;
        test_load_flag;
        test_single_cycle;
        test_multi_shift;
        test_amt_zero;
        test_abort;
        test_mode7;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
